// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed 32x32 Booth multiplier and 32/32 restoring divider
// Optional build macro: MULTDIV_FAST_PATH_EN (trivial mult/div skip the iterations)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             MultOut,
    output logic             DivOut,
    output logic             divZero,
    output logic             busy,
    output logic [WIDTH-1:0] HIOut,
    output logic [WIDTH-1:0] LOOut
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MRUN = 3'd1;
    localparam logic [2:0] DRUN = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] HOLD = 3'd4;

    logic [2:0]         state;
    logic [CW-1:0]      count;
    logic               op_div;
    logic               sign_q;
    logic               sign_r;
    // {partial product (WIDTH+1), multiplier (WIDTH), Q-1}; the extra top bit absorbs -(-2^31)
    logic [2*WIDTH+1:0] acc;
    logic [WIDTH:0]     mcand;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvs;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     booth_hi;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH+1:0] booth_next;
    logic [WIDTH:0]     shifted;
    logic               sub_ok;
    logic [WIDTH-1:0]   rem_next;

    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;

    assign booth_hi = acc[2*WIDTH+1:WIDTH+1];
    always_comb begin
        booth_sum = booth_hi;
        case (acc[1:0])
            2'b01:   booth_sum = booth_hi + mcand;
            2'b10:   booth_sum = booth_hi - mcand;
            default: booth_sum = booth_hi;
        endcase
    end
    assign booth_next = {booth_sum[WIDTH], booth_sum, acc[WIDTH:1]};

    // The remainder after a successful subtract is below the divisor, so WIDTH bits suffice
    assign shifted  = {rem, quo[WIDTH-1]};
    assign sub_ok   = shifted >= {1'b0, dvs};
    assign rem_next = sub_ok ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];

    assign MultOut = (state == DONE) && !op_div;
    assign DivOut  = (state == DONE) && op_div;
    assign busy    = ((state == MRUN) || (state == DRUN)) && (count != LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            op_div  <= 1'b0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            divZero <= 1'b0;
            HIOut   <= '0;
            LOOut   <= '0;
        end else begin
            divZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (MultCtrl) begin
                        op_div <= 1'b0;
                        mcand  <= {A[WIDTH-1], A};
                        acc    <= {{(WIDTH+1){1'b0}}, B, 1'b0};
                        count  <= '0;
                        state  <= MRUN;
`ifdef MULTDIV_FAST_PATH_EN
                        if ((A == '0) || (B == '0)) begin
                            acc   <= '0;
                            count <= LAST;
                        end
`endif
                    end else if (DivCtrl) begin
                        op_div <= 1'b1;
                        if (B == '0) begin
                            divZero <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            dvs    <= b_mag;
                            quo    <= a_mag;
                            rem    <= '0;
                            sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            sign_r <= A[WIDTH-1];
                            count  <= '0;
                            state  <= DRUN;
`ifdef MULTDIV_FAST_PATH_EN
                            if (a_mag < b_mag) begin
                                quo   <= '0;
                                rem   <= a_mag;
                                count <= LAST;
                            end
`endif
                        end
                    end
                end
                MRUN: begin
                    if (!MultCtrl) begin
                        state <= IDLE;
                    end else if (count == LAST) begin
                        HIOut <= acc[2*WIDTH:WIDTH+1];
                        LOOut <= acc[WIDTH:1];
                        state <= DONE;
                    end else begin
                        acc   <= booth_next;
                        count <= count + CW'(1);
                    end
                end
                DRUN: begin
                    if (!DivCtrl) begin
                        state <= IDLE;
                    end else if (count == LAST) begin
                        LOOut <= sign_q ? -quo : quo;
                        HIOut <= sign_r ? -rem : rem;
                        state <= DONE;
                    end else begin
                        rem   <= rem_next;
                        quo   <= {quo[WIDTH-2:0], sub_ok};
                        count <= count + CW'(1);
                    end
                end
                DONE: state <= HOLD;
                HOLD: begin
                    if (op_div ? !DivCtrl : !MultCtrl)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed and randomized bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MultCtrl;
    logic        DivCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        MultOut;
    logic        DivOut;
    logic        divZero;
    logic        busy;
    logic [31:0] HIOut;
    logic [31:0] LOOut;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .MultCtrl(MultCtrl), .DivCtrl(DivCtrl),
        .A(A), .B(B), .MultOut(MultOut), .DivOut(DivOut), .divZero(divZero),
        .busy(busy), .HIOut(HIOut), .LOOut(LOOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // {remainder, quotient}; 64-bit arithmetic so -2^31 / -1 wraps to 0x80000000 naturally
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic longint mag(input logic [31:0] v);
        longint x;
        x = longint'($signed(v));
        return (x < 0) ? -x : x;
    endfunction

    function automatic int ref_lat(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        bit fast;
`ifdef MULTDIV_FAST_PATH_EN
        fast = is_div ? (mag(a) < mag(b)) : ((a == 0) || (b == 0));
`else
        fast = 1'b0;
`endif
        return fast ? 2 : 34;
    endfunction

    task automatic run_op(input string tag, input bit is_div, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat, cyc, busy_n;
        bit seen;
        exp = is_div ? ref_div(a, b) : ref_mult(a, b);
        lat = ref_lat(is_div, a, b);
        A = a;
        B = b;
        if (is_div) DivCtrl = 1'b1; else MultCtrl = 1'b1;
        @(posedge clk);
        cyc = 0;
        busy_n = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            A = $urandom;
            B = $urandom;
            if (busy) busy_n++;
            seen = is_div ? DivOut : MultOut;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_hilo"}, {HIOut, LOOut}, exp);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'((lat == 34) ? 32 : 0));
        MultCtrl = 1'b0;
        DivCtrl = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_width"}, {62'd0, MultOut, DivOut}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int cnt_a, cnt_b;
        logic [31:0] ra, rb;
        bit rd;
        reset = 1'b0;
        MultCtrl = 1'b0;
        DivCtrl = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {28'd0, MultOut, DivOut, divZero, busy, HIOut}, 64'd0);
        check("reset_lo", {32'd0, LOOut}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD);
        run_op("mult_min_min", 1'b0, 32'h80000000, 32'h80000000);
        run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);

        // divide by zero: single pulse, no restart while DivCtrl stays high
        A = 32'd5;
        B = 32'd0;
        DivCtrl = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("divzero_pulse", {63'd0, divZero}, 64'd1);
        cnt_a = 0;
        cnt_b = 0;
        repeat (10) begin
            @(negedge clk);
            if (divZero) cnt_a++;
            if (DivOut || busy) cnt_b++;
        end
        check("divzero_no_repeat", 64'(cnt_a), 64'd0);
        check("divzero_no_run", 64'(cnt_b), 64'd0);
        check("divzero_hilo_kept", {HIOut, LOOut}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        DivCtrl = 1'b0;
        repeat (2) @(negedge clk);

        // abort a multiply after ten cycles
        run_op("mult_3_4", 1'b0, 32'd3, 32'd4);
        A = 32'd5;
        B = 32'd6;
        MultCtrl = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        MultCtrl = 1'b0;
        cnt_a = 0;
        repeat (40) begin
            @(negedge clk);
            if (MultOut || busy) cnt_a++;
        end
        check("abort_no_done", 64'(cnt_a), 64'd0);
        check("abort_hilo_kept", {HIOut, LOOut}, {32'd0, 32'd12});

        run_op("div_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_op("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7);
        run_op("mult_0_9", 1'b0, 32'd0, 32'd9);

        for (int i = 0; i < 16; i++) begin
            rd = 1'($urandom);
            case ($urandom % 4)
                0: ra = $urandom;
                1: ra = 32'($signed($urandom_range(0, 40)) - 20);
                2: ra = 32'h80000000;
                default: ra = 32'd0;
            endcase
            case ($urandom % 3)
                0: rb = $urandom;
                1: rb = 32'($signed($urandom_range(0, 40)) - 20);
                default: rb = 32'hFFFFFFFF;
            endcase
            if (rd && rb == 0) rb = 32'd1;
            run_op($sformatf("rand%0d_%s", i, rd ? "div" : "mult"), rd, ra, rb);
        end

        // reset in the middle of a divide
        A = 32'd1000;
        B = 32'd3;
        DivCtrl = 1'b1;
        @(posedge clk);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_flags", {60'd0, MultOut, DivOut, divZero, busy}, 64'd0);
        check("midreset_hilo", {HIOut, LOOut}, 64'd0);
        DivCtrl = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
